// File: rtl/bram_rdata_collect_pkg.sv
// Shared BRAM control constants: array geometry plus the default shape of the
// read-data collector that gathers enabled bank outputs into compute lanes.
package bram_rdata_collect_pkg;

   localparam int BIGS       = 4;
   localparam int SMALLS     = 16;

   localparam int BANKS_DEF  = 32;
   localparam int LANES_DEF  = 4;
   localparam int DW_DEF     = 16;
   localparam int RD_LAT_DEF = 2;
   localparam int DEPTH_DEF  = 4;

endpackage

// File: rtl/bram_rdata_collect_fifo.sv
// Small output FIFO for collected lane entries; empty head reads as zero and a
// push into a full FIFO survives only if the head leaves in the same cycle.
module collect_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop_ready,
   output logic         out_valid,
   output logic [W-1:0] head,
   output logic         drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign full      = (count == CW'(DEPTH));
   assign out_valid = (count != '0);
   assign do_pop    = out_valid && pop_ready;
   assign do_push   = push && (!full || do_pop);
   assign drop      = push && !do_push;
   assign head      = out_valid ? mem[rd_ptr] : '0;

   // clr wins over any push/pop landing on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)
            count <= count + CW'(1);
         else if (do_pop && !do_push)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !clr)
         mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/bram_rdata_collect.sv
// Collects data from the enabled BRAM banks once their read latency elapses,
// packs them into the low lanes and queues the result for the SA/pool units.
module bram_rdata_collect
   import bram_rdata_collect_pkg::*;
#(
   parameter int BANKS  = BANKS_DEF,
   parameter int LANES  = LANES_DEF,
   parameter int DW     = DW_DEF,
   parameter int RD_LAT = RD_LAT_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic [BANKS-1:0]         en,
   input  logic [BANKS*DW-1:0]      rdata,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [LANES*DW-1:0]      out_data,
   output logic [LANES-1:0]         out_mask,
   output logic [$clog2(BANKS)-1:0] out_base,
   output logic                     overflow,
   output logic                     multi_err
);

   localparam int AW = $clog2(BANKS);
   localparam int FW = LANES*DW + LANES + AW;

   logic [BANKS-1:0]    pipe [RD_LAT];
   logic [BANKS-1:0]    en_d;
   logic [LANES*DW-1:0] lane_data;
   logic [LANES-1:0]    lane_mask;
   logic [AW-1:0]       base;
   logic                too_many;
   logic [FW-1:0]       head;
   logic                drop;

   // en travels alongside the BRAM read so en_d lines up with rdata
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++)
            pipe[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < RD_LAT; i++)
            pipe[i] <= '0;
      end else begin
         pipe[0] <= en;
         for (int i = 1; i < RD_LAT; i++)
            pipe[i] <= pipe[i-1];
      end
   end

   assign en_d = pipe[RD_LAT-1];

   // Bank b lands in lane n, where n counts the enabled banks below b
   always_comb begin
      int n;
      lane_data = '0;
      lane_mask = '0;
      base      = '0;
      n         = 0;
      for (int b = BANKS-1; b >= 0; b--)
         if (en_d[b])
            base = AW'(b);
      for (int b = 0; b < BANKS; b++) begin
         if (en_d[b]) begin
            for (int k = 0; k < LANES; k++) begin
               if (n == k) begin
                  lane_data[k*DW +: DW] = rdata[b*DW +: DW];
                  lane_mask[k]          = 1'b1;
               end
            end
            n = n + 1;
         end
      end
      too_many = (n > LANES);
   end

   collect_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .push      (|en_d),
      .wdata     ({lane_data, lane_mask, base}),
      .pop_ready (out_ready),
      .out_valid (out_valid),
      .head      (head),
      .drop      (drop)
   );

   assign {out_data, out_mask, out_base} = head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         multi_err <= 1'b0;
      end else if (clr) begin
         overflow  <= 1'b0;
         multi_err <= 1'b0;
      end else begin
         overflow  <= overflow | drop;
         multi_err <= multi_err | too_many;
      end
   end

endmodule

// File: tb/tb_bram_rdata_collect.sv
// Scoreboard bench for bram_rdata_collect: directed enable patterns against a
// fixed bank pattern (bank b reads b+1), checked as entries leave the FIFO.
module tb_bram_rdata_collect;

   localparam int BANKS = 32;
   localparam int LANES = 4;
   localparam int DW    = 16;
   localparam int AW    = 5;

   typedef struct packed {
      logic [LANES*DW-1:0] data;
      logic [LANES-1:0]    mask;
      logic [AW-1:0]       base;
   } entry_t;

   logic                clk;
   logic                rst_n;
   logic                clr;
   logic [BANKS-1:0]    en;
   logic [BANKS*DW-1:0] rdata;
   logic                out_ready;
   logic                out_valid;
   logic [LANES*DW-1:0] out_data;
   logic [LANES-1:0]    out_mask;
   logic [AW-1:0]       out_base;
   logic                overflow;
   logic                multi_err;

   entry_t sb[$];
   int     vectors;
   int     miscompares;

   bram_rdata_collect dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .en        (en),
      .rdata     (rdata),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_mask  (out_mask),
      .out_base  (out_base),
      .overflow  (overflow),
      .multi_err (multi_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic entry_t mk(input logic [63:0] d, input logic [3:0] m, input logic [4:0] b);
      entry_t e;
      e.data = d;
      e.mask = m;
      e.base = b;
      return e;
   endfunction

   task automatic check_output(input string name, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Drives en for exactly one cycle; returns #1 after the capturing edge
   task automatic apply_stimulus(input logic [31:0] e, input entry_t exp, input bit expect_push);
      en = e;
      if (expect_push)
         sb.push_back(exp);
      @(posedge clk);
      #1;
      en = '0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++)
         @(posedge clk);
      #1;
      check_output("drain", 128'(sb.size()), 128'd0);
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_entry: got %0h expected none", {out_data, out_mask, out_base});
         end else begin
            entry_t e;
            e = sb.pop_front();
            check_output("entry", 128'({out_data, out_mask, out_base}), 128'(e));
         end
      end
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      clr         = 1'b0;
      en          = '0;
      out_ready   = 1'b0;
      for (int b = 0; b < BANKS; b++)
         rdata[b*DW +: DW] = 16'(b + 1);

      @(posedge clk);
      #1;
      check_output("rst_valid", 128'(out_valid), 128'd0);
      check_output("rst_data", 128'(out_data), 128'd0);
      check_output("rst_mask", 128'(out_mask), 128'd0);
      check_output("rst_base", 128'(out_base), 128'd0);
      check_output("rst_flags", 128'({overflow, multi_err}), 128'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Low four banks, with latency check
      apply_stimulus(32'h0000_000F, mk(64'h0004_0003_0002_0001, 4'hF, 5'd0), 1'b1);
      @(posedge clk);
      #1;
      check_output("lat_early", 128'(out_valid), 128'd0);
      @(posedge clk);
      #1;
      check_output("lat_exact", 128'(out_valid), 128'd1);
      wait_drain();

      apply_stimulus(32'h00F0_0000, mk(64'h0018_0017_0016_0015, 4'hF, 5'd20), 1'b1);
      wait_drain();
      apply_stimulus(32'h0000_0005, mk(64'h0000_0000_0003_0001, 4'b0011, 5'd0), 1'b1);
      wait_drain();
      check_output("no_multi", 128'(multi_err), 128'd0);

      // Five banks: the fifth is cut and the error sticks until clr
      apply_stimulus(32'h0000_001F, mk(64'h0004_0003_0002_0001, 4'hF, 5'd0), 1'b1);
      wait_drain();
      check_output("multi_set", 128'(multi_err), 128'd1);
      repeat (5) @(posedge clk);
      #1;
      check_output("multi_held", 128'(multi_err), 128'd1);
      pulse_clr();
      check_output("multi_clr", 128'(multi_err), 128'd0);

      // Stall output, overfill by one
      out_ready = 1'b0;
      apply_stimulus(32'h0000_0001, mk(64'h1, 4'b0001, 5'd0), 1'b1);
      apply_stimulus(32'h0000_0002, mk(64'h2, 4'b0001, 5'd1), 1'b1);
      apply_stimulus(32'h0000_0004, mk(64'h3, 4'b0001, 5'd2), 1'b1);
      apply_stimulus(32'h0000_0008, mk(64'h4, 4'b0001, 5'd3), 1'b1);
      apply_stimulus(32'h0000_0010, mk(64'h5, 4'b0001, 5'd4), 1'b0);
      repeat (4) @(posedge clk);
      #1;
      check_output("ovf_set", 128'(overflow), 128'd1);
      check_output("full_valid", 128'(out_valid), 128'd1);
      check_output("head_hold0", 128'({out_data, out_base}), 128'({64'h1, 5'd0}));
      repeat (3) @(posedge clk);
      #1;
      check_output("head_hold1", 128'({out_data, out_base}), 128'({64'h1, 5'd0}));
      out_ready = 1'b1;
      wait_drain();
      check_output("drained_valid", 128'(out_valid), 128'd0);
      check_output("ovf_held", 128'(overflow), 128'd1);
      pulse_clr();
      check_output("ovf_clr", 128'(overflow), 128'd0);

      // Reset with three stored entries and two still in the pipe
      out_ready = 1'b0;
      apply_stimulus(32'h0000_001F, mk(64'h0, 4'h0, 5'd0), 1'b0);
      apply_stimulus(32'h0000_0002, mk(64'h0, 4'h0, 5'd0), 1'b0);
      apply_stimulus(32'h0000_0004, mk(64'h0, 4'h0, 5'd0), 1'b0);
      apply_stimulus(32'h0000_0008, mk(64'h0, 4'h0, 5'd0), 1'b0);
      apply_stimulus(32'h0000_0010, mk(64'h0, 4'h0, 5'd0), 1'b0);
      check_output("pre_rst_valid", 128'(out_valid), 128'd1);
      check_output("pre_rst_multi", 128'(multi_err), 128'd1);
      rst_n = 1'b0;
      #1;
      check_output("mid_rst_valid", 128'(out_valid), 128'd0);
      check_output("mid_rst_outs", 128'({out_data, out_mask, out_base}), 128'd0);
      check_output("mid_rst_flags", 128'({overflow, multi_err}), 128'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check_output("post_rst_valid", 128'(out_valid), 128'd0);
      check_output("sb_empty", 128'(sb.size()), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
